// File: rtl/frame_accumulator.sv
// Sums FRAME_LEN unsigned products into one frame total, presented on a valid/ready output.
// Optional clamping with sticky per-frame overflow when FRAME_ACC_SATURATE_EN is defined.
module frame_accumulator #(
  parameter int DATA_SIZE   = 16,
  parameter int FRAME_LEN   = 8,
  parameter int ACC_SIZE    = DATA_SIZE + $clog2(FRAME_LEN),
  localparam int CNT_SIZE   = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_SIZE-1:0]  out_sum,
  output logic [CNT_SIZE-1:0]  out_count,
  output logic                 out_overflow
);

  localparam logic [CNT_SIZE-1:0] LAST_CNT = CNT_SIZE'(FRAME_LEN - 1);

  typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

`ifdef FRAME_ACC_SATURATE_EN
  function automatic logic add_ovf(input logic [ACC_SIZE-1:0] acc,
                                   input logic [DATA_SIZE-1:0] data);
    logic [ACC_SIZE:0] s;
    s = {1'b0, acc} + (ACC_SIZE+1)'(data);
    return s[ACC_SIZE];
  endfunction

  function automatic logic [ACC_SIZE-1:0] acc_add(input logic [ACC_SIZE-1:0] acc,
                                                  input logic [DATA_SIZE-1:0] data);
    logic [ACC_SIZE:0] s;
    s = {1'b0, acc} + (ACC_SIZE+1)'(data);
    return s[ACC_SIZE] ? {ACC_SIZE{1'b1}} : s[ACC_SIZE-1:0];
  endfunction
`else
  function automatic logic [ACC_SIZE-1:0] acc_add(input logic [ACC_SIZE-1:0] acc,
                                                  input logic [DATA_SIZE-1:0] data);
    return acc + ACC_SIZE'(data);
  endfunction
`endif

  state_t              r_state;
  logic [ACC_SIZE-1:0] r_acc;
  logic [CNT_SIZE-1:0] r_cnt;
  logic [ACC_SIZE-1:0] r_sum;
  logic [CNT_SIZE-1:0] r_count;

  logic                w_accept;
  logic                w_close;
  logic [ACC_SIZE-1:0] w_acc_next;
  logic [CNT_SIZE-1:0] w_cnt_next;

  always_comb begin
    w_accept   = in_valid && (r_state == ST_ACCUM);
    w_acc_next = w_accept ? acc_add(r_acc, in_data) : r_acc;
    w_cnt_next = r_cnt + CNT_SIZE'(w_accept);
    // A lone flush on an empty frame must not emit anything.
    w_close    = (r_state == ST_ACCUM) &&
                 ((w_accept && (r_cnt == LAST_CNT)) ||
                  (flush && ((r_cnt != '0) || w_accept)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_close) begin
            r_sum   <= w_acc_next;
            r_count <= w_cnt_next;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_HOLD;
          end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
          end
        end
        ST_HOLD: begin
          if (out_ready) r_state <= ST_ACCUM;
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

`ifdef FRAME_ACC_SATURATE_EN
  logic r_frame_ovf;
  logic r_ovf;
  logic w_ovf_next;

  always_comb begin
    w_ovf_next = r_frame_ovf | (w_accept & add_ovf(r_acc, in_data));
  end

  // Sticky flag follows the accumulator: latched out at close, cleared with acc.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_frame_ovf <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (r_state == ST_ACCUM) begin
      if (w_close) begin
        r_ovf       <= w_ovf_next;
        r_frame_ovf <= 1'b0;
      end else begin
        r_frame_ovf <= w_ovf_next;
      end
    end
  end

  assign out_overflow = r_ovf;
`else
  assign out_overflow = 1'b0;
`endif

  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_HOLD);
  assign out_sum   = r_sum;
  assign out_count = r_count;

endmodule

// File: tb/tb_frame_accumulator.sv
// Directed bench for frame_accumulator: three instances cover FRAME_LEN=4 (ACC 10 and 9) and FRAME_LEN=1.
module tb_frame_accumulator;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: DATA 8, FRAME_LEN 4, ACC 10
  logic       a_in_valid = 0, a_in_ready, a_flush = 0, a_out_valid, a_out_ready = 1, a_out_overflow;
  logic [7:0] a_in_data = 0;
  logic [9:0] a_out_sum;
  logic [2:0] a_out_count;

  // Instance B: DATA 8, FRAME_LEN 4, ACC 9
  logic       b_in_valid = 0, b_in_ready, b_flush = 0, b_out_valid, b_out_ready = 1, b_out_overflow;
  logic [7:0] b_in_data = 0;
  logic [8:0] b_out_sum;
  logic [2:0] b_out_count;

  // Instance C: DATA 8, FRAME_LEN 1, ACC 8
  logic       c_in_valid = 0, c_in_ready, c_flush = 0, c_out_valid, c_out_ready = 1, c_out_overflow;
  logic [7:0] c_in_data = 0;
  logic [7:0] c_out_sum;
  logic [0:0] c_out_count;

  frame_accumulator #(.DATA_SIZE(8), .FRAME_LEN(4), .ACC_SIZE(10)) u_a (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_count(a_out_count), .out_overflow(a_out_overflow));

  frame_accumulator #(.DATA_SIZE(8), .FRAME_LEN(4), .ACC_SIZE(9)) u_b (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_count(b_out_count), .out_overflow(b_out_overflow));

  frame_accumulator #(.DATA_SIZE(8), .FRAME_LEN(1), .ACC_SIZE(8)) u_c (
    .clock(clock), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .flush(c_flush), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_count(c_out_count), .out_overflow(c_out_overflow));

  task automatic a_beats4(input int d0, input int d1, input int d2, input int d3);
    int vals[4];
    vals = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); a_in_valid = 1'b1; a_in_data = 8'(vals[i]);
    end
    @(negedge clock); a_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0d want 0", a_out_valid); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0d want 1", a_in_ready); end
    n_tests++; if (a_out_sum !== 10'd0) begin n_fail++; $display("FAIL reset_out_sum got %0d want 0", a_out_sum); end
    n_tests++; if (a_out_count !== 3'd0) begin n_fail++; $display("FAIL reset_out_count got %0d want 0", a_out_count); end
    n_tests++; if (a_out_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_out_overflow got %0d want 0", a_out_overflow); end
  endtask

  task automatic test_frame();
    a_out_ready = 1'b1;
    a_beats4(10, 20, 30, 40);
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL frame_out_valid got %0d want 1", a_out_valid); end
    n_tests++; if (a_out_sum !== 10'd100) begin n_fail++; $display("FAIL frame_out_sum got %0d want 100", a_out_sum); end
    n_tests++; if (a_out_count !== 3'd4) begin n_fail++; $display("FAIL frame_out_count got %0d want 4", a_out_count); end
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL frame_in_ready_hold got %0d want 0", a_in_ready); end
    @(negedge clock);
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL frame_out_valid_drop got %0d want 0", a_out_valid); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL frame_in_ready_back got %0d want 1", a_in_ready); end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_beats4(10, 20, 30, 40);
    a_in_valid = 1'b1; a_in_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got %0d want 1", i, a_out_valid); end
      n_tests++; if (a_out_sum !== 10'd100) begin n_fail++; $display("FAIL bp_out_sum[%0d] got %0d want 100", i, a_out_sum); end
      n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %0d want 0", i, a_in_ready); end
      @(negedge clock);
    end
    a_out_ready = 1'b1; a_in_valid = 1'b0;
    @(negedge clock);
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %0d want 0", a_out_valid); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0d want 1", a_in_ready); end
    a_beats4(1, 2, 3, 4);
    n_tests++; if (a_out_sum !== 10'd10) begin n_fail++; $display("FAIL bp_next_frame_sum got %0d want 10", a_out_sum); end
    n_tests++; if (a_out_count !== 3'd4) begin n_fail++; $display("FAIL bp_next_frame_count got %0d want 4", a_out_count); end
    @(negedge clock);
  endtask

  task automatic test_flush();
    @(negedge clock); a_in_valid = 1'b1; a_in_data = 8'd5;
    @(negedge clock); a_in_data = 8'd7;
    @(negedge clock); a_in_valid = 1'b0; a_flush = 1'b1;
    @(negedge clock); a_flush = 1'b0;
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got %0d want 1", a_out_valid); end
    n_tests++; if (a_out_sum !== 10'd12) begin n_fail++; $display("FAIL flush_sum got %0d want 12", a_out_sum); end
    n_tests++; if (a_out_count !== 3'd2) begin n_fail++; $display("FAIL flush_count got %0d want 2", a_out_count); end
    @(negedge clock); a_flush = 1'b1;
    @(negedge clock); a_flush = 1'b0;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid got %0d want 0", a_out_valid); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_ready got %0d want 1", a_in_ready); end
    a_in_valid = 1'b1; a_in_data = 8'd3;
    @(negedge clock); a_flush = 1'b1;
    @(negedge clock); a_in_valid = 1'b0; a_flush = 1'b0;
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_beat_valid got %0d want 1", a_out_valid); end
    n_tests++; if (a_out_sum !== 10'd6) begin n_fail++; $display("FAIL flush_beat_sum got %0d want 6", a_out_sum); end
    n_tests++; if (a_out_count !== 3'd2) begin n_fail++; $display("FAIL flush_beat_count got %0d want 2", a_out_count); end
    @(negedge clock);
  endtask

  task automatic test_overflow();
    int exp_sum;
    int exp_ovf;
`ifdef FRAME_ACC_SATURATE_EN
    exp_sum = 511; exp_ovf = 1;
`else
    exp_sum = 508; exp_ovf = 0;
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); b_in_valid = 1'b1; b_in_data = 8'd255;
    end
    @(negedge clock); b_in_valid = 1'b0;
    n_tests++; if (b_out_sum !== 9'(exp_sum)) begin n_fail++; $display("FAIL ovf_sum got %0d want %0d", b_out_sum, exp_sum); end
    n_tests++; if (b_out_overflow !== 1'(exp_ovf)) begin n_fail++; $display("FAIL ovf_flag got %0d want %0d", b_out_overflow, exp_ovf); end
    n_tests++; if (b_out_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", b_out_count); end
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); b_in_valid = 1'b1; b_in_data = 8'd1;
    end
    @(negedge clock); b_in_valid = 1'b0;
    n_tests++; if (b_out_sum !== 9'd4) begin n_fail++; $display("FAIL ovf_next_sum got %0d want 4", b_out_sum); end
    n_tests++; if (b_out_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_next_flag got %0d want 0", b_out_overflow); end
    @(negedge clock);
  endtask

  task automatic test_mid_reset();
    @(negedge clock); a_in_valid = 1'b1; a_in_data = 8'd9;
    @(negedge clock); a_in_data = 8'd9;
    @(negedge clock); a_in_valid = 1'b0; reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mreset_valid got %0d want 0", a_out_valid); end
    n_tests++; if (a_out_sum !== 10'd0) begin n_fail++; $display("FAIL mreset_sum got %0d want 0", a_out_sum); end
    a_beats4(1, 1, 1, 1);
    n_tests++; if (a_out_sum !== 10'd4) begin n_fail++; $display("FAIL mreset_frame_sum got %0d want 4", a_out_sum); end
    n_tests++; if (a_out_count !== 3'd4) begin n_fail++; $display("FAIL mreset_frame_count got %0d want 4", a_out_count); end
    @(negedge clock);
    a_out_ready = 1'b0;
    a_beats4(2, 2, 2, 2);
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL hreset_pre_valid got %0d want 1", a_out_valid); end
    n_tests++; if (a_out_sum !== 10'd8) begin n_fail++; $display("FAIL hreset_pre_sum got %0d want 8", a_out_sum); end
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL hreset_valid got %0d want 0", a_out_valid); end
    n_tests++; if (a_out_sum !== 10'd0) begin n_fail++; $display("FAIL hreset_sum got %0d want 0", a_out_sum); end
    n_tests++; if (a_out_count !== 3'd0) begin n_fail++; $display("FAIL hreset_count got %0d want 0", a_out_count); end
    a_out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    c_out_ready = 1'b1;
    @(negedge clock); c_in_valid = 1'b1; c_in_data = 8'd7;
    @(negedge clock); c_in_data = 8'd8;
    n_tests++; if (c_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid got %0d want 1", c_out_valid); end
    n_tests++; if (c_out_sum !== 8'd7) begin n_fail++; $display("FAIL b2b_first_sum got %0d want 7", c_out_sum); end
    n_tests++; if (c_out_count !== 1'd1) begin n_fail++; $display("FAIL b2b_first_count got %0d want 1", c_out_count); end
    n_tests++; if (c_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble_ready got %0d want 0", c_in_ready); end
    @(negedge clock);
    n_tests++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid got %0d want 0", c_out_valid); end
    n_tests++; if (c_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ready got %0d want 1", c_in_ready); end
    @(negedge clock); c_in_valid = 1'b0;
    n_tests++; if (c_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got %0d want 1", c_out_valid); end
    n_tests++; if (c_out_sum !== 8'd8) begin n_fail++; $display("FAIL b2b_second_sum got %0d want 8", c_out_sum); end
    n_tests++; if (c_out_count !== 1'd1) begin n_fail++; $display("FAIL b2b_second_count got %0d want 1", c_out_count); end
    n_tests++; if (c_out_overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got %0d want 0", c_out_overflow); end
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_flush();
    test_overflow();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_accumulator.md
Name: frame_accumulator

Overview:
Downstream consumer of the multiply_and_add product stream. It sums a frame of FRAME_LEN products into one wide accumulator and presents the frame sum on a valid/ready output. A flush input closes a partial frame early. It applies backpressure to the product source while a finished sum waits to be taken.

Parameters:
DATA_SIZE, OUTPUT_SIZE (params package), width of each incoming product, unsigned.
FRAME_LEN, 8, products per frame, >= 1.
ACC_SIZE, DATA_SIZE + $clog2(FRAME_LEN), accumulator and out_sum width, >= DATA_SIZE.
CNT_SIZE, $clog2(FRAME_LEN+1), derived (localparam), width of out_count.

Ports:
clock  input  1  single clock, all logic on posedge.
reset  input  1  synchronous, active-high.
in_valid  input  1  product beat present.
in_ready  output  1  block accepts a beat this cycle.
in_data  input  DATA_SIZE  product value, unsigned.
flush  input  1  close the current partial frame.
out_valid  output  1  frame sum available.
out_ready  input  1  consumer takes the sum.
out_sum  output  ACC_SIZE  frame sum.
out_count  output  CNT_SIZE  number of beats in the emitted frame.
out_overflow  output  1  sum clamped (see Optional Feature).

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Accept rule: a beat is accepted when in_valid && in_ready.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
  - in_ready is a pure decode of state. No combinational path from out_ready to in_ready.
- Reset values: state=ACCUM, acc=0, count=0, out_sum=0, out_count=0, out_overflow=0, out_valid=0.
- ACCUM, beat accepted, count < FRAME_LEN-1, no flush: acc <= acc+in_data; count <= count+1.
- ACCUM, frame close:
  - Trigger A: beat accepted with count == FRAME_LEN-1.
  - Trigger B: flush=1 with (count > 0 or a beat accepted this cycle).
  - On close: out_sum <= acc + (accepted ? in_data : 0); out_count <= count + accepted; acc <= 0; count <= 0; go to HOLD.
  - The beat accepted in the flush cycle is included in the frame.
- ACCUM, flush=1 with count == 0 and no beat: no effect, no output.
- HOLD:
  - out_sum, out_count and out_overflow stay stable.
  - in_valid is ignored (not accepted). flush is ignored.
  - out_ready=1 returns to ACCUM on the next cycle; out_valid drops then.
- Latency: sum is valid on the cycle after the closing beat or flush.
- Throughput: one bubble cycle minimum per frame (the HOLD cycle).
- FRAME_LEN=1: every accepted beat closes a frame with out_count=1.
- Arithmetic: unsigned, zero-extend in_data to ACC_SIZE. Overflow handling is set by the Optional Feature.
- Reset mid-frame or in HOLD: partial sum and pending output are discarded; all registers return to reset values.
- Upstream note: multiply_and_add has no stall input, so the source driving in_valid must honour in_ready.

Optional Feature:
Macro: FRAME_ACC_SATURATE_EN.
- Defined:
  - Any addition exceeding 2^ACC_SIZE-1 clamps acc to 2^ACC_SIZE-1 and sets a sticky per-frame overflow bit.
  - The bit is copied to out_overflow at frame close and cleared with acc.
- Undefined:
  - Additions wrap modulo 2^ACC_SIZE.
  - out_overflow is tied to 0.
- Port list is identical in both builds.

Test Plan:
1. DATA_SIZE=8, FRAME_LEN=4, ACC_SIZE=10, out_ready=1; beats 10,20,30,40 back-to-back after reset -> out_valid=1 on the cycle after the 4th accept; out_sum=100, out_count=4; in_ready=0 that cycle, then 1.
2. Same config, out_ready=0 for 5 cycles after the frame closes, in_valid held high with 99 -> out_sum stays 100 and in_ready=0 throughout; no beat absorbed. out_ready=1 -> ACCUM next cycle; the next frame starts from acc=0.
3. Flush cases:
   - Beats 5,7 then flush -> out_sum=12, out_count=2.
   - Flush with count=0 and no beat -> out_valid stays 0.
   - Beat 3, then beat 3 together with flush -> out_sum=6, out_count=2.
4. ACC_SIZE=9, four beats of 255:
   - Without FRAME_ACC_SATURATE_EN -> out_sum=508, out_overflow=0.
   - With it -> out_sum=511, out_overflow=1; the following frame 1,1,1,1 -> out_sum=4, out_overflow=0.
5. Reset asserted for 1 cycle after beats 9,9 -> out_valid=0, then four beats of 1 -> out_sum=4, out_count=4. Reset asserted during HOLD -> out_valid drops next cycle, out_sum=0.
6. FRAME_LEN=1, beats 7,8 with out_ready=1 -> outputs 7 then 8, each with out_count=1; one bubble between accepts.
